// File: rtl/v_wb_collector_pkg.sv
// v_wb_collector_pkg: shared types and constants for the writeback collector
// Holds the buffered write entry, the bank-alignment derivation and the collector state encoding.
package v_wb_collector_pkg;
    localparam int WB_DATA_WIDTH = 64;
    localparam int WB_ADDR_WIDTH = 10;
    localparam int WB_BANK_COUNT = 4;
    localparam int WB_BE_WIDTH = WB_DATA_WIDTH / 8;

    function automatic int align_bits(input int banks);
        return $clog2(banks);
    endfunction

    localparam int WB_ALIGN_BITS = align_bits(WB_BANK_COUNT);

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
        logic [WB_BE_WIDTH-1:0]   be;
    } wb_entry_t;

    typedef enum logic [1:0] {WB_IDLE, WB_RUN, WB_DRAIN} wb_state_t;
endpackage

// File: rtl/v_wb_fifo.sv
// v_wb_fifo: synchronous FIFO of writeback entries with occupancy, full and empty
// Ports: clk, rst (sync, active-high); push/din write an entry; pop/dout read the head
//   (dout is zero while empty); count, full, empty report occupancy.
module v_wb_fifo
    import v_wb_collector_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     din,
    input  logic          pop,
    output wb_entry_t     dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign empty = count == '0;
    assign full = count == CW'(DEPTH);
    assign do_pop = pop && !empty;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/v_wb_collector.sv
// v_wb_collector: writeback collector merging narrow halves into a FIFO that drives one banked VRF write port
// Ports: clk, rst (sync, active-high); start_pulse/narrow_mode open an instruction;
//   in_valid/in_last/in_addr/in_be/in_data carry result beats; stall back-pressures the source;
//   wr_en/wr_ready/wr_bank/wr_row/wr_data/wr_be form the VRF write port;
//   busy, wb_done (one-cycle completion) and err (sticky protocol error) report status.
module v_wb_collector
    import v_wb_collector_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int BANK_COUNT = WB_BANK_COUNT,
    parameter int FIFO_DEPTH = 4,
    localparam int ALIGN_BITS = align_bits(BANK_COUNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_pulse,
    input  logic                         narrow_mode,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [ADDR_WIDTH-1:0]        in_addr,
    input  logic [DATA_WIDTH/8-1:0]      in_be,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         stall,
    output logic                         wr_en,
    input  logic                         wr_ready,
    output logic [ALIGN_BITS-1:0]        wr_bank,
    output logic [ADDR_WIDTH-ALIGN_BITS-1:0] wr_row,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH/8-1:0]      wr_be,
    output logic                         busy,
    output logic                         wb_done,
    output logic                         err
);
    localparam int H = DATA_WIDTH / 2;
    localparam int B = DATA_WIDTH / 16;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_state_t state, state_n;
    logic nm, mv, mv_n, cap, push, pop, full, empty, done, err_set, accept, live, same;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [H-1:0] m_data;
    logic [B-1:0] m_be;
    logic [CW-1:0] count, count_n;
    wb_entry_t push_e, head;

    v_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(push_e),
        .pop(pop),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    assign accept = in_valid && state == WB_RUN;
    assign live = accept && |in_be;
    assign same = in_addr == m_addr;
    assign pop = !empty && wr_ready;
    assign count_n = count + CW'(push && (!full || pop)) - CW'(pop);
    assign err_set = (start_pulse && state != WB_IDLE) || (in_valid && state != WB_RUN)
                   || (live && nm && mv && !same) || (push && full && !pop);

    // push source: the pending half (upper half empty) unless a beat supplies the word
    always_comb begin
        push_e.addr = m_addr;
        push_e.data = {{H{1'b0}}, m_data};
        push_e.be = {{B{1'b0}}, m_be};
        push = 1'b0;
        cap = 1'b0;
        mv_n = mv;
        if (live && !nm) begin
            push = 1'b1;
            push_e.addr = in_addr;
            push_e.data = in_data;
            push_e.be = in_be;
        end else if (live && !mv && !in_last) begin
            cap = 1'b1;
            mv_n = 1'b1;
        end else if (live && !mv) begin
            push = 1'b1;
            push_e.addr = in_addr;
            push_e.data = {{H{1'b0}}, in_data[H-1:0]};
            push_e.be = {{B{1'b0}}, in_be[B-1:0]};
        end else if (live && same) begin
            push = 1'b1;
            push_e.data = {in_data[H-1:0], m_data};
            push_e.be = {in_be[B-1:0], m_be};
            mv_n = 1'b0;
        end else if (live) begin
            // address mismatch: stale half leaves alone, this beat restarts pairing
            push = 1'b1;
            cap = 1'b1;
        end else if (state == WB_DRAIN && mv && (!full || pop)) begin
            push = 1'b1;
            mv_n = 1'b0;
        end
    end

    // leaving DRAIN looks at next-cycle occupancy so wb_done lands right after the last write
    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            WB_IDLE: state_n = start_pulse ? WB_RUN : WB_IDLE;
            WB_RUN: state_n = (accept && in_last) ? WB_DRAIN : WB_RUN;
            WB_DRAIN: begin
                done = count_n == '0 && !mv_n;
                state_n = done ? WB_IDLE : WB_DRAIN;
            end
            default: state_n = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WB_IDLE;
            nm <= 1'b0;
            mv <= 1'b0;
            m_addr <= '0;
            m_data <= '0;
            m_be <= '0;
            stall <= 1'b0;
            wb_done <= 1'b0;
            err <= 1'b0;
        end else begin
            state <= state_n;
            mv <= state == WB_IDLE ? 1'b0 : mv_n;
            if (state == WB_IDLE && start_pulse) nm <= narrow_mode;
            if (cap) begin
                m_addr <= in_addr;
                m_data <= in_data[H-1:0];
                m_be <= in_be[B-1:0];
            end
            stall <= count_n >= CW'(FIFO_DEPTH - 1);
            wb_done <= done;
            err <= err | err_set;
        end
    end

    assign wr_en = !empty;
    assign wr_bank = head.addr[ALIGN_BITS-1:0];
    assign wr_row = head.addr[ADDR_WIDTH-1:ALIGN_BITS];
    assign wr_data = head.data;
    assign wr_be = head.be;
    assign busy = state != WB_IDLE;
endmodule
